idelay_tap_cal: RTL and testbench
=================================

Name: idelay_tap_cal

Overview:
- Per-lane calibration FSM that drives the load/tap interface of the ADC data-lane IDELAYE3 wrapper, one instance per delayed data lane.
- On request it sweeps every tap, checks the deserialized training pattern at each tap, and finds the widest contiguous passing window.
- It then loads the centre tap of that window and reports the eye start and width.
- Sits in the clk_div domain between the ADC SPI/training sequencer (upstream) and the delay wrapper (downstream). The deserialized lane word is fed back into it.

Parameters:
- TAP_W, 9: width of the tap value; matches the IDELAYE3 counter width.
- MAX_TAP, 511: last tap in the sweep; the sweep covers 0..MAX_TAP inclusive.
- DATA_W, 8: width of the deserialized lane word.
- PATTERN, 8'hAA: expected training word.
- SETTLE_CYC, 16: wait cycles after each load, before checking. Must be ≥4.
- CHECK_CYC, 64: number of words compared per tap.
- MIN_EYE, 4: minimum passing-window width, in taps, for success.

Ports:
- clk_div  in  1: lane divided clock; all logic is on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: single-cycle request to begin calibration. Ignored while busy.
- data_in  in  DATA_W: deserialized lane word, valid every clk_div cycle.
- tap_value  out  TAP_W: tap presented to the delay wrapper.
- load  out  1: single-cycle pulse that loads tap_value into the delay.
- busy  out  1: high from the accepted start until DONE.
- done  out  1: level; high after a calibration completes, cleared by the next accepted start.
- cal_fail  out  1: level; valid while done is high.
- eye_start  out  TAP_W: first tap of the best window.
- eye_width  out  TAP_W+1: width of the best window, in taps.

Behaviour:
- Reset: all outputs are 0; the FSM is in IDLE. Reset is asynchronous and aborts any sweep immediately. The delay wrapper independently returns to its DELAY_VALUE.
- States:
  - IDLE: wait for start.
  - LOAD: load=1 for exactly one cycle, with tap_value = current tap.
  - SETTLE: count SETTLE_CYC cycles.
  - CHECK: count CHECK_CYC cycles. Any cycle with data_in != PATTERN marks the tap as failing.
  - EVAL: update the window trackers. If tap == MAX_TAP go to FINAL; otherwise increment tap and go to LOAD.
  - FINAL: close any open window, compute the result, set tap_value to the result tap.
  - CENTER: pulse load for one cycle with the result tap.
  - DONE: set done=1 and busy=0, then return to IDLE.
- Transitions: IDLE→LOAD on start with tap=0 and busy=1. done and cal_fail clear in the same cycle.
- tap_value is held stable from LOAD through the end of SETTLE. This covers the wrapper's 2-stage load pipeline plus 1 cycle of margin; hence SETTLE_CYC ≥ 4.
- Window tracking uses registers cur_start, cur_len, best_start and best_len.
  - Passing tap: if cur_len==0, cur_start=tap; then cur_len++.
  - Failing tap: close the current window, then set cur_len=0.
  - Close rule: if cur_len > best_len (strictly), copy cur_start/cur_len into best. On a tie the earlier window wins.
  - A window still open at MAX_TAP is closed in FINAL.
- Result:
  - If best_len ≥ MIN_EYE: tap = best_start + (best_len >> 1), computed with a TAP_W+1-bit sum and truncated (it cannot overflow, since best_start + best_len ≤ MAX_TAP+1); cal_fail=0.
  - Otherwise: tap = 0 and cal_fail=1. CENTER still loads 0.
- eye_start and eye_width show best_start and best_len from FINAL onward, and hold until the next start.
- A start asserted in the same cycle as DONE is ignored. A start is accepted only in IDLE.
- Latency per tap = 1 + SETTLE_CYC + CHECK_CYC + 1 cycles. Total = (MAX_TAP+1) × per-tap latency + 3 cycles.
- data_in is ignored outside CHECK.

Decomposition:
- Shared package adc_cal_pkg holds:
  - the state enum;
  - default constants TAP_W, PATTERN and MIN_EYE;
  - a function for the centre-tap computation.
- One sub-module, cal_window_track: holds the cur/best registers plus the close logic. Inputs: clear, step, pass, tap, close. Outputs: best_start, best_len.
- The FSM and counters live in the top level.

Test Plan (bench uses MAX_TAP=31, SETTLE_CYC=4, CHECK_CYC=8):
1. Pattern passes only at taps 10..20 → eye_start=10, eye_width=11, final tap_value=15, cal_fail=0. Exactly 33 load pulses in total: 32 sweep + 1 centre.
2. Two windows, taps 3..5 and 12..19 → eye_start=12, eye_width=8, tap=16.
3. Equal windows at taps 2..6 and 20..24 → the earlier wins: eye_start=2, tap=4.
4. Window 28..31 open at the end of the sweep → closed in FINAL: eye_start=28, width=4, tap=30. Same window with MIN_EYE=5 → cal_fail=1, tap=0.
5. All taps fail, or a single mismatching word injected in each CHECK → cal_fail=1, eye_width=0, final load with tap 0. Also: a second start during busy is ignored.
6. Assert rst during SETTLE of tap 7 → all outputs are 0 asynchronously. A following start sweeps from tap 0. tap_value must be stable for ≥3 cycles after every load pulse (assertion).

Source files
------------

// File: rtl/adc_cal_pkg.sv
// Shared types and helpers for the ADC lane delay calibration logic.
package adc_cal_pkg;

    localparam int         DEF_TAP_W   = 9;
    localparam logic [7:0] DEF_PATTERN = 8'hAA;
    localparam int         DEF_MIN_EYE = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_EVAL,
        ST_FINAL,
        ST_CENTER,
        ST_DONE
    } cal_state_t;

    // Centre of a window. The sum is wide enough that it never wraps; the
    // caller truncates to the tap width (start + width never exceeds the
    // tap range plus one).
    function automatic logic [31:0] center_tap(input logic [31:0] start_tap,
                                               input logic [31:0] width);
        return start_tap + (width >> 1);
    endfunction

endpackage

// File: rtl/cal_window_track.sv
// Tracks the current run of passing taps and the widest run seen so far.
// best_start/best_len are presented as they would be once the open window
// is closed, so the result is usable in the same cycle that close is raised.
module cal_window_track
    import adc_cal_pkg::*;
#(
    parameter int TAP_W = DEF_TAP_W
) (
    input  logic             clk_div,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    input  logic             close,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W:0]   best_len
);

    logic [TAP_W-1:0] cur_start;
    logic [TAP_W:0]   cur_len;
    logic [TAP_W-1:0] best_start_q;
    logic [TAP_W:0]   best_len_q;
    logic             take_cur;

    // Strictly wider only: on a tie the earlier window is kept.
    always_comb begin
        take_cur   = (cur_len > best_len_q);
        best_start = take_cur ? cur_start : best_start_q;
        best_len   = take_cur ? cur_len   : best_len_q;
    end

    // Extend the open window on a pass; close it on a fail or at the end.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            cur_start    <= '0;
            cur_len      <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (clear) begin
            cur_start    <= '0;
            cur_len      <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (step) begin
            if (pass) begin
                if (cur_len == '0)
                    cur_start <= tap;
                cur_len <= cur_len + (TAP_W+1)'(1);
            end else begin
                if (take_cur) begin
                    best_start_q <= cur_start;
                    best_len_q   <= cur_len;
                end
                cur_len <= '0;
            end
        end else if (close) begin
            if (take_cur) begin
                best_start_q <= cur_start;
                best_len_q   <= cur_len;
            end
            cur_len <= '0;
        end
    end

endmodule

// File: rtl/idelay_tap_cal.sv
// Per-lane IDELAY tap sweep: finds the widest passing window of the
// training pattern and loads its centre tap.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | one-cycle load pulse with the current sweep tap
// SETTLE | let the delay line settle after the load
// CHECK  | compare data_in against the training word
// EVAL   | feed pass/fail to the window tracker, advance the tap
// FINAL  | close open window, compute the centre tap
// CENTER | one-cycle load pulse with the result tap
// DONE   | report completion, back to IDLE
module idelay_tap_cal
    import adc_cal_pkg::*;
#(
    parameter int                TAP_W      = DEF_TAP_W,
    parameter int                MAX_TAP    = 511,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] PATTERN    = DEF_PATTERN,
    parameter int                SETTLE_CYC = 16,
    parameter int                CHECK_CYC  = 64,
    parameter int                MIN_EYE    = DEF_MIN_EYE
) (
    input  logic              clk_div,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic [TAP_W-1:0]  tap_value,
    output logic              load,
    output logic              busy,
    output logic              done,
    output logic              cal_fail,
    output logic [TAP_W-1:0]  eye_start,
    output logic [TAP_W:0]    eye_width
);

    localparam int CNT_MAX = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    cal_state_t       state;
    logic [TAP_W-1:0] tap;
    logic [CNT_W-1:0] cnt;
    logic             tap_fail;

    logic             trk_clear;
    logic             trk_step;
    logic             trk_close;
    logic [TAP_W-1:0] best_start;
    logic [TAP_W:0]   best_len;

    assign trk_clear = (state == ST_IDLE) && start;
    assign trk_step  = (state == ST_EVAL);
    assign trk_close = (state == ST_FINAL);

    cal_window_track #(
        .TAP_W (TAP_W)
    ) u_track (
        .clk_div    (clk_div),
        .rst        (rst),
        .clear      (trk_clear),
        .step       (trk_step),
        .pass       (~tap_fail),
        .tap        (tap),
        .close      (trk_close),
        .best_start (best_start),
        .best_len   (best_len)
    );

    // Sweep sequencer with registered outputs; tap_value only changes on
    // entry to LOAD, FINAL result, or a new start, so it is held through SETTLE.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tap       <= '0;
            cnt       <= '0;
            tap_fail  <= 1'b0;
            tap_value <= '0;
            load      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cal_fail  <= 1'b0;
            eye_start <= '0;
            eye_width <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tap       <= '0;
                        tap_value <= '0;
                        load      <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        cal_fail  <= 1'b0;
                        eye_start <= '0;
                        eye_width <= '0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load  <= 1'b0;
                    cnt   <= CNT_W'(SETTLE_CYC - 1);
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        cnt      <= CNT_W'(CHECK_CYC - 1);
                        tap_fail <= 1'b0;
                        state    <= ST_CHECK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (data_in != PATTERN)
                        tap_fail <= 1'b1;
                    if (cnt == '0)
                        state <= ST_EVAL;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                ST_EVAL: begin
                    if (tap == TAP_W'(MAX_TAP)) begin
                        state <= ST_FINAL;
                    end else begin
                        tap       <= tap + TAP_W'(1);
                        tap_value <= tap + TAP_W'(1);
                        load      <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_FINAL: begin
                    eye_start <= best_start;
                    eye_width <= best_len;
                    if (best_len >= (TAP_W+1)'(MIN_EYE)) begin
                        tap_value <= TAP_W'(center_tap(32'(best_start), 32'(best_len)));
                        cal_fail  <= 1'b0;
                    end else begin
                        tap_value <= '0;
                        cal_fail  <= 1'b1;
                    end
                    load  <= 1'b1;
                    state <= ST_CENTER;
                end
                ST_CENTER: begin
                    load  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idelay_tap_cal.sv
// Directed bench for idelay_tap_cal with a short sweep (taps 0..31).
module tb_idelay_tap_cal;

    localparam int TAP_W  = 9;
    localparam int MAXT   = 31;
    localparam int SETTLE = 4;
    localparam int CHK    = 8;
    localparam int PER    = 1 + SETTLE + CHK + 1;
    localparam int BUSY_N = (MAXT + 1) * PER + 2;

    logic             clk_div = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       data_in;

    logic [TAP_W-1:0] tap_value, tap_value5;
    logic             load, load5;
    logic             busy, busy5;
    logic             done, done5;
    logic             cal_fail, cal_fail5;
    logic [TAP_W-1:0] eye_start, eye_start5;
    logic [TAP_W:0]   eye_width, eye_width5;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]      mask = '0;
    bit               glitch = 1'b0;
    int               n_loads = 0;
    int               offset = 100;
    int               cur_tap = 0;
    int               first_tap = -1;
    int               hold_cnt = 0;
    logic [TAP_W-1:0] hold_val = '0;
    bit               hold_bad = 1'b0;
    int               busy_cyc = 0;

    idelay_tap_cal #(
        .TAP_W(TAP_W), .MAX_TAP(MAXT), .DATA_W(8), .PATTERN(8'hAA),
        .SETTLE_CYC(SETTLE), .CHECK_CYC(CHK), .MIN_EYE(4)
    ) dut (
        .clk_div(clk_div), .rst(rst), .start(start), .data_in(data_in),
        .tap_value(tap_value), .load(load), .busy(busy), .done(done),
        .cal_fail(cal_fail), .eye_start(eye_start), .eye_width(eye_width)
    );

    idelay_tap_cal #(
        .TAP_W(TAP_W), .MAX_TAP(MAXT), .DATA_W(8), .PATTERN(8'hAA),
        .SETTLE_CYC(SETTLE), .CHECK_CYC(CHK), .MIN_EYE(5)
    ) dut5 (
        .clk_div(clk_div), .rst(rst), .start(start), .data_in(data_in),
        .tap_value(tap_value5), .load(load5), .busy(busy5), .done(done5),
        .cal_fail(cal_fail5), .eye_start(eye_start5), .eye_width(eye_width5)
    );

    always #5 clk_div = ~clk_div;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rmask(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Lane model: word offset within each tap drives the training word only
    // inside the CHECK slot of a passing tap; also watches tap_value hold.
    initial begin
        data_in = 8'h55;
        forever begin
            @(posedge clk_div);
            #1;
            if (rst) begin
                offset   = 100;
                hold_cnt = 0;
            end else if (load) begin
                if (n_loads == 0) first_tap = int'(tap_value);
                offset   = 0;
                cur_tap  = n_loads;
                n_loads++;
                hold_val = tap_value;
                hold_cnt = 3;
                hold_bad = 1'b0;
            end else begin
                if (offset < 100) offset++;
                if (hold_cnt > 0) begin
                    if (tap_value !== hold_val) hold_bad = 1'b1;
                    hold_cnt--;
                    if (hold_cnt == 0) check("tap_hold", 32'(hold_bad), 0);
                end
            end
            if (offset >= 1 + SETTLE && offset <= SETTLE + CHK && cur_tap <= MAXT &&
                mask[cur_tap] && !(glitch && offset == SETTLE + 4))
                data_in = 8'hAA;
            else
                data_in = 8'h55;
        end
    end

    task automatic run_cal(input logic [31:0] m, input bit g, input bit restart_busy,
                           input bit start_at_done);
        bit seen_done;
        mask = m;
        glitch = g;
        repeat (5) @(negedge clk_div);
        n_loads   = 0;
        first_tap = -1;
        busy_cyc  = 0;
        seen_done = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_div);
            #2;
            start = 1'b0;
            if (busy) busy_cyc++;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (restart_busy && busy_cyc == 100) start = 1'b1;
        end
        check("done_seen", 32'(seen_done), 1);
        if (start_at_done) begin
            start = 1'b1;
            @(posedge clk_div);
            #2;
            start = 1'b0;
            check("start_in_done_busy", 32'(busy), 0);
            check("start_in_done_done", 32'(done), 1);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check("rst_tap_value", 32'(tap_value), 0);
        check("rst_load", 32'(load), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cal_fail", 32'(cal_fail), 0);
        check("rst_eye_start", 32'(eye_start), 0);
        check("rst_eye_width", 32'(eye_width), 0);
        repeat (3) @(negedge clk_div);
        rst = 1'b0;

        // single window 10..20
        run_cal(rmask(10, 20), 1'b0, 1'b0, 1'b0);
        check("t1_first_tap", 32'(first_tap), 0);
        check("t1_eye_start", 32'(eye_start), 10);
        check("t1_eye_width", 32'(eye_width), 11);
        check("t1_tap", 32'(tap_value), 15);
        check("t1_cal_fail", 32'(cal_fail), 0);
        check("t1_loads", 32'(n_loads), 33);
        check("t1_busy_cycles", 32'(busy_cyc), BUSY_N);

        // two windows, wider one later
        run_cal(rmask(3, 5) | rmask(12, 19), 1'b0, 1'b0, 1'b0);
        check("t2_eye_start", 32'(eye_start), 12);
        check("t2_eye_width", 32'(eye_width), 8);
        check("t2_tap", 32'(tap_value), 16);
        check("t2_cal_fail", 32'(cal_fail), 0);

        // equal windows: earlier one kept; start during DONE ignored
        run_cal(rmask(2, 6) | rmask(20, 24), 1'b0, 1'b0, 1'b1);
        check("t3_eye_start", 32'(eye_start), 2);
        check("t3_eye_width", 32'(eye_width), 5);
        check("t3_tap", 32'(tap_value), 4);

        // window open at end of sweep; MIN_EYE=5 instance rejects it
        run_cal(rmask(28, 31), 1'b0, 1'b0, 1'b0);
        check("t4_eye_start", 32'(eye_start), 28);
        check("t4_eye_width", 32'(eye_width), 4);
        check("t4_tap", 32'(tap_value), 30);
        check("t4_cal_fail", 32'(cal_fail), 0);
        check("t4m5_eye_start", 32'(eye_start5), 28);
        check("t4m5_eye_width", 32'(eye_width5), 4);
        check("t4m5_tap", 32'(tap_value5), 0);
        check("t4m5_cal_fail", 32'(cal_fail5), 1);

        // all taps fail, with a second start while busy
        run_cal(32'h0, 1'b0, 1'b1, 1'b0);
        check("t5a_cal_fail", 32'(cal_fail), 1);
        check("t5a_eye_width", 32'(eye_width), 0);
        check("t5a_eye_start", 32'(eye_start), 0);
        check("t5a_tap", 32'(tap_value), 0);
        check("t5a_loads", 32'(n_loads), 33);
        check("t5a_busy_cycles", 32'(busy_cyc), BUSY_N);

        // one bad word inside every CHECK
        run_cal(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        check("t5b_cal_fail", 32'(cal_fail), 1);
        check("t5b_eye_width", 32'(eye_width), 0);
        check("t5b_tap", 32'(tap_value), 0);

        // reset during SETTLE of tap 7
        mask   = rmask(10, 20);
        glitch = 1'b0;
        repeat (3) @(negedge clk_div);
        n_loads = 0;
        start = 1'b1;
        @(negedge clk_div);
        start = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk_div);
            #2;
            if (n_loads == 8) break;
        end
        check("t6_reached_tap7", 32'(n_loads), 8);
        @(posedge clk_div);
        @(posedge clk_div);
        #3;
        check("t6_tap7_settle", 32'(tap_value), 7);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_tap_value", 32'(tap_value), 0);
        check("t6_rst_load", 32'(load), 0);
        check("t6_rst_done", 32'(done), 0);
        check("t6_rst_cal_fail", 32'(cal_fail), 0);
        check("t6_rst_eye_width", 32'(eye_width), 0);
        check("t6m5_rst_busy", 32'(busy5), 0);
        @(negedge clk_div);
        @(negedge clk_div);
        rst = 1'b0;
        run_cal(rmask(10, 20), 1'b0, 1'b0, 1'b0);
        check("t6_first_tap", 32'(first_tap), 0);
        check("t6_eye_start", 32'(eye_start), 10);
        check("t6_eye_width", 32'(eye_width), 11);
        check("t6_tap", 32'(tap_value), 15);
        check("t6_loads", 32'(n_loads), 33);

        repeat (5) @(negedge clk_div);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
